// File: rtl/video_upscale.sv
`default_nettype none
// video_upscale: 2x nearest-neighbour RGB565 upscaler. Input lines are captured
// into a ping-pong line buffer and each one is replayed twice with pixels doubled.
// Rev 1.0
module video_upscale #(
  parameter int IN_X    = 640,
  parameter int IN_Y    = 360,
  parameter int H_BLANK = 16,
  parameter int ADDR_W  = 10
) (
  input  logic        pclk_in,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        href_in,
  input  logic        de_in,
  input  logic [15:0] i_rgb565_in,
  output logic        vsync_out,
  output logic        href_out,
  output logic [15:0] i_rgb565_out,
  output logic        overrun,
  output logic        short_line
);

  localparam int XW = ADDR_W + 1;
  localparam int YW = (IN_Y > 1) ? $clog2(IN_Y) : 1;
  localparam int BW = (H_BLANK > 0) ? $clog2(H_BLANK + 1) : 1;

  localparam logic [XW-1:0] C_IN_X    = XW'(IN_X);
  localparam logic [XW-1:0] C_RD_LAST = XW'(2 * IN_X - 1);
  localparam logic [YW-1:0] C_Y_LAST  = YW'(IN_Y - 1);
  localparam logic [BW-1:0] C_BLK_END = BW'(H_BLANK - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACT0 = 3'd1;
  localparam logic [2:0] S_BLK0 = 3'd2;
  localparam logic [2:0] S_ACT1 = 3'd3;
  localparam logic [2:0] S_BLK1 = 3'd4;

  logic [15:0]   mem0 [2**ADDR_W];
  logic [15:0]   mem1 [2**ADDR_W];
  logic [15:0]   rdata;
  logic [2:0]    state;
  logic [XW-1:0] wr_x, rd_x, cur_x;
  logic [BW-1:0] blk;
  logic [YW-1:0] in_y;
  logic [1:0]    full, full_nx;
  logic          wr_bank, rd_bank, line_ok, cur_ok;
  logic          href_d, vs_d, act_d;
  logic          vs_rise, href_rise, href_fall, wr_en, commit, short_ev;
  logic          blk_done, release_ev, is_act;
  logic [ADDR_W-1:0] rd_addr;

  assign vs_rise    = vsync_in & ~vs_d;
  assign href_rise  = href_in & ~href_d;
  assign href_fall  = ~href_in & href_d;
  // The rising-edge cycle already carries a pixel, so use next-state values there.
  assign cur_ok     = href_rise ? ~full[wr_bank] : line_ok;
  assign cur_x      = href_rise ? '0 : wr_x;
  assign wr_en      = href_in & de_in & cur_ok & (cur_x < C_IN_X);
  assign commit     = href_fall & line_ok & (wr_x == C_IN_X);
  assign short_ev   = href_fall & line_ok & (wr_x != C_IN_X);
  assign blk_done   = (blk == C_BLK_END);
  assign release_ev = (state == S_BLK1) & blk_done;
  assign is_act     = (state == S_ACT0) | (state == S_ACT1);
  assign rd_addr    = rd_x[ADDR_W:1];

  always_comb begin
    full_nx = full;
    if (commit)     full_nx[wr_bank] = 1'b1;
    if (release_ev) full_nx[rd_bank] = 1'b0;
  end

  always_ff @(posedge pclk_in) begin
    if (wr_en) begin
      if (wr_bank) mem1[cur_x[ADDR_W-1:0]] <= i_rgb565_in;
      else         mem0[cur_x[ADDR_W-1:0]] <= i_rgb565_in;
    end
  end

  always_ff @(posedge pclk_in) begin
    if (is_act) rdata <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

  always_ff @(posedge pclk_in) begin
    if (rst) begin
      vs_d         <= 1'b0;
      vsync_out    <= 1'b0;
      href_d       <= 1'b0;
      href_out     <= 1'b0;
      act_d        <= 1'b0;
      i_rgb565_out <= '0;
      overrun      <= 1'b0;
      short_line   <= 1'b0;
      full         <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      line_ok      <= 1'b0;
      wr_x         <= '0;
      rd_x         <= '0;
      blk          <= '0;
      in_y         <= '0;
      state        <= S_IDLE;
    end else begin
      vs_d      <= vsync_in;
      vsync_out <= vs_d;
      href_d    <= href_in;
      if (vs_rise) begin
        href_out     <= 1'b0;
        act_d        <= 1'b0;
        i_rgb565_out <= '0;
        overrun      <= 1'b0;
        short_line   <= 1'b0;
        full         <= '0;
        wr_bank      <= 1'b0;
        rd_bank      <= 1'b0;
        line_ok      <= 1'b0;
        wr_x         <= '0;
        rd_x         <= '0;
        blk          <= '0;
        in_y         <= '0;
        state        <= S_IDLE;
      end else begin
        act_d        <= is_act;
        href_out     <= act_d;
        i_rgb565_out <= act_d ? rdata : '0;
        wr_x         <= wr_en ? cur_x + 1'b1 : cur_x;
        full         <= full_nx;
        if (href_rise) begin
          line_ok <= ~full[wr_bank];
          if (full[wr_bank]) overrun <= 1'b1;
        end else if (href_fall) begin
          line_ok <= 1'b0;
        end
        if (short_ev) short_line <= 1'b1;
        if (commit) begin
          wr_bank <= ~wr_bank;
          in_y    <= (in_y == C_Y_LAST) ? '0 : in_y + 1'b1;
        end
        if (release_ev) rd_bank <= ~rd_bank;

        case (state)
          S_IDLE: begin
            rd_x <= '0;
            if (full[rd_bank]) state <= S_ACT0;
          end
          S_ACT0, S_ACT1: begin
            if (rd_x == C_RD_LAST) begin
              rd_x  <= '0;
              blk   <= '0;
              state <= (state == S_ACT0) ? S_BLK0 : S_BLK1;
            end else begin
              rd_x <= rd_x + 1'b1;
            end
          end
          S_BLK0: begin
            if (blk_done) begin
              blk   <= '0;
              state <= S_ACT1;
            end else begin
              blk <= blk + 1'b1;
            end
          end
          S_BLK1: begin
            if (blk_done) begin
              blk   <= '0;
              state <= full_nx[~rd_bank] ? S_ACT0 : S_IDLE;
            end else begin
              blk <= blk + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_upscale.sv
`default_nettype none
`timescale 1ns/1ps
// tb_video_upscale: randomized scenarios against a line-replay reference model.
module tb_video_upscale;

  localparam int IN_X    = 16;
  localparam int IN_Y    = 6;
  localparam int H_BLANK = 4;
  localparam int ADDR_W  = 5;
  localparam int SAFE_PERIOD = 2 * (2 * IN_X + H_BLANK) + 8;

  logic        pclk_in = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_in = 1'b0;
  logic        href_in = 1'b0;
  logic        de_in = 1'b0;
  logic [15:0] rgb_in = '0;
  logic        vsync_out, href_out, overrun, short_line;
  logic [15:0] rgb_out;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] line_buf [64];
  logic [15:0] exp_pix [$];
  logic [15:0] got_pix [$];
  int          got_len [$];
  int          got_gap [$];
  int          low_nz;
  logic        prev_h;
  int          run_len, gap_len;
  bit          seen_fall;

  always #5 pclk_in = ~pclk_in;

  video_upscale #(.IN_X(IN_X), .IN_Y(IN_Y), .H_BLANK(H_BLANK), .ADDR_W(ADDR_W)) dut (
    .pclk_in     (pclk_in),
    .rst         (rst),
    .vsync_in    (vsync_in),
    .href_in     (href_in),
    .de_in       (de_in),
    .i_rgb565_in (rgb_in),
    .vsync_out   (vsync_out),
    .href_out    (href_out),
    .i_rgb565_out(rgb_out),
    .overrun     (overrun),
    .short_line  (short_line)
  );

  // Output capture: pixel stream, burst lengths, inter-burst gaps.
  always @(negedge pclk_in) begin
    if (href_out === 1'b1) begin
      if (!prev_h && seen_fall) got_gap.push_back(gap_len);
      got_pix.push_back(rgb_out);
      run_len++;
    end else begin
      if (prev_h) begin
        got_len.push_back(run_len);
        run_len   = 0;
        gap_len   = 0;
        seen_fall = 1;
      end
      gap_len++;
      if (rgb_out !== 16'h0000) low_nz++;
    end
    prev_h = href_out;
  end

  task automatic clear_capture();
    @(posedge pclk_in);
    got_pix.delete(); got_len.delete(); got_gap.delete(); exp_pix.delete();
    low_nz = 0; prev_h = 0; run_len = 0; gap_len = 0; seen_fall = 0;
    @(negedge pclk_in);
  endtask

  function automatic void fill_line(input bit ramp);
    for (int i = 0; i < 64; i++) line_buf[i] = ramp ? 16'(i) : 16'($urandom);
  endfunction

  // Reference: a committed line appears as two output lines, each pixel twice.
  function automatic void expect_line();
    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < 2 * IN_X; k++) exp_pix.push_back(line_buf[k / 2]);
  endfunction

  task automatic send_line(input int n_px, input int gap_pct, input int period);
    int hi = 0;
    int idx = 0;
    href_in = 1'b1;
    while (idx < n_px) begin
      de_in  = ($urandom_range(99) >= gap_pct);
      rgb_in = de_in ? line_buf[idx] : 16'($urandom);
      if (de_in) idx++;
      hi++;
      @(negedge pclk_in);
    end
    href_in = 1'b0; de_in = 1'b0; rgb_in = '0;
    repeat ((period - hi > 4) ? period - hi : 4) @(negedge pclk_in);
  endtask

  task automatic pulse_vsync();
    vsync_in = 1'b1;
    repeat (3) @(negedge pclk_in);
    vsync_in = 1'b0;
    repeat (3) @(negedge pclk_in);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge pclk_in);
    n_cmp++; if (href_out !== 1'b0) begin n_fail++; $display("FAIL reset_href got=%b want=0", href_out); end
    n_cmp++; if (rgb_out !== 16'h0) begin n_fail++; $display("FAIL reset_rgb got=%h want=0000", rgb_out); end
    n_cmp++; if (vsync_out !== 1'b0) begin n_fail++; $display("FAIL reset_vsync got=%b want=0", vsync_out); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    n_cmp++; if (short_line !== 1'b0) begin n_fail++; $display("FAIL reset_short got=%b want=0", short_line); end
    rst = 1'b0;
    repeat (2) @(negedge pclk_in);
  endtask

  task automatic test_single_line();
    clear_capture();
    fill_line(1'b1);
    expect_line();
    send_line(IN_X, 0, SAFE_PERIOD);
    repeat (SAFE_PERIOD) @(negedge pclk_in);
    n_cmp++; if (got_len.size() != 2) begin n_fail++; $display("FAIL single_bursts got=%0d want=2", got_len.size()); end
    foreach (got_len[i]) begin
      n_cmp++; if (got_len[i] != 2 * IN_X) begin n_fail++; $display("FAIL single_len[%0d] got=%0d want=%0d", i, got_len[i], 2 * IN_X); end
    end
    n_cmp++; if (got_gap.size() != 1 || got_gap[0] != H_BLANK) begin n_fail++; $display("FAIL single_gap got=%0d want=%0d", (got_gap.size() > 0) ? got_gap[0] : -1, H_BLANK); end
    n_cmp++; if (got_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL single_count got=%0d want=%0d", got_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL single_pix[%0d] got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
    if (got_pix.size() >= 2) begin
      n_cmp++; if (got_pix[0] !== 16'h0 || got_pix[1] !== 16'h0) begin n_fail++; $display("FAIL single_first got=%h,%h want=0000,0000", got_pix[0], got_pix[1]); end
      n_cmp++; if (got_pix[got_pix.size() - 1] !== 16'(IN_X - 1)) begin n_fail++; $display("FAIL single_last got=%h want=%h", got_pix[got_pix.size() - 1], 16'(IN_X - 1)); end
    end
    n_cmp++; if (low_nz != 0) begin n_fail++; $display("FAIL single_idle_rgb got=%0d want=0", low_nz); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL single_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_random_frame();
    int n_lines = IN_Y + 2;
    pulse_vsync();
    clear_capture();
    for (int l = 0; l < n_lines; l++) begin
      fill_line(1'b0);
      expect_line();
      send_line(IN_X + $urandom_range(0, 3), 20, SAFE_PERIOD);
    end
    repeat (3 * SAFE_PERIOD) @(negedge pclk_in);
    n_cmp++; if (got_len.size() != 2 * n_lines) begin n_fail++; $display("FAIL frame_bursts got=%0d want=%0d", got_len.size(), 2 * n_lines); end
    foreach (got_len[i]) begin
      n_cmp++; if (got_len[i] != 2 * IN_X) begin n_fail++; $display("FAIL frame_len[%0d] got=%0d want=%0d", i, got_len[i], 2 * IN_X); end
    end
    foreach (got_gap[i]) begin
      n_cmp++; if (got_gap[i] < H_BLANK) begin n_fail++; $display("FAIL frame_gap[%0d] got=%0d want>=%0d", i, got_gap[i], H_BLANK); end
    end
    n_cmp++; if (got_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL frame_count got=%0d want=%0d", got_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL frame_pix[%0d] got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
    n_cmp++; if (low_nz != 0) begin n_fail++; $display("FAIL frame_idle_rgb got=%0d want=0", low_nz); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL frame_overrun got=%b want=0", overrun); end
    n_cmp++; if (short_line !== 1'b0) begin n_fail++; $display("FAIL frame_short got=%b want=0", short_line); end
  endtask

  task automatic test_overrun();
    int fast = IN_X + 12;
    pulse_vsync();
    clear_capture();
    fill_line(1'b0); expect_line(); send_line(IN_X, 0, fast);
    fill_line(1'b0); expect_line(); send_line(IN_X, 0, fast);
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before got=%b want=0", overrun); end
    fill_line(1'b0); send_line(IN_X, 0, fast);
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_line2 got=%b want=1", overrun); end
    fill_line(1'b0); send_line(IN_X, 0, fast);
    repeat (3 * SAFE_PERIOD) @(negedge pclk_in);
    n_cmp++; if (got_len.size() != 4) begin n_fail++; $display("FAIL ovr_bursts got=%0d want=4", got_len.size()); end
    n_cmp++; if (got_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL ovr_count got=%0d want=%0d", got_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL ovr_pix[%0d] got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
    pulse_vsync();
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared got=%b want=0", overrun); end
  endtask

  task automatic test_short_line();
    pulse_vsync();
    clear_capture();
    fill_line(1'b0); send_line(IN_X - 4, 0, SAFE_PERIOD);
    n_cmp++; if (short_line !== 1'b1) begin n_fail++; $display("FAIL short_flag got=%b want=1", short_line); end
    fill_line(1'b0); expect_line(); send_line(IN_X, 10, SAFE_PERIOD);
    repeat (2 * SAFE_PERIOD) @(negedge pclk_in);
    n_cmp++; if (got_len.size() != 2) begin n_fail++; $display("FAIL short_bursts got=%0d want=2", got_len.size()); end
    n_cmp++; if (got_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL short_count got=%0d want=%0d", got_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL short_pix[%0d] got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
    n_cmp++; if (short_line !== 1'b1) begin n_fail++; $display("FAIL short_sticky got=%b want=1", short_line); end
  endtask

  task automatic test_vsync_flush();
    int t = 0;
    pulse_vsync();
    clear_capture();
    fill_line(1'b0); send_line(IN_X - 3, 0, 8);
    fill_line(1'b0); send_line(IN_X, 0, 0);
    while (got_pix.size() < 10 && t < 300) begin @(negedge pclk_in); t++; end
    n_cmp++; if (t >= 300) begin n_fail++; $display("FAIL flush_wait got=timeout want=burst"); end
    vsync_in = 1'b1;
    @(negedge pclk_in);
    n_cmp++; if (href_out !== 1'b0) begin n_fail++; $display("FAIL flush_href got=%b want=0", href_out); end
    n_cmp++; if (vsync_out !== 1'b0) begin n_fail++; $display("FAIL flush_vs1 got=%b want=0", vsync_out); end
    n_cmp++; if (short_line !== 1'b0) begin n_fail++; $display("FAIL flush_short got=%b want=0", short_line); end
    @(negedge pclk_in);
    n_cmp++; if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL flush_vs2 got=%b want=1", vsync_out); end
    vsync_in = 1'b0;
    repeat (SAFE_PERIOD) @(negedge pclk_in);
    n_cmp++; if (got_len.size() != 1 || got_len[0] >= 2 * IN_X) begin n_fail++; $display("FAIL flush_trunc got=%0d bursts want=1 truncated", got_len.size()); end
    clear_capture();
    fill_line(1'b0); expect_line(); send_line(IN_X, 0, SAFE_PERIOD);
    repeat (SAFE_PERIOD) @(negedge pclk_in);
    n_cmp++; if (got_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL flush_next_count got=%0d want=%0d", got_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL flush_next_pix[%0d] got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
  endtask

  task automatic test_rst_mid();
    int t = 0;
    pulse_vsync();
    clear_capture();
    fill_line(1'b0); send_line(IN_X, 0, 0);
    while (got_pix.size() < 2 * IN_X + 8 && t < 400) begin @(negedge pclk_in); t++; end
    n_cmp++; if (t >= 400) begin n_fail++; $display("FAIL rst_wait got=timeout want=second burst"); end
    rst = 1'b1;
    @(negedge pclk_in);
    rst = 1'b0;
    n_cmp++; if (href_out !== 1'b0) begin n_fail++; $display("FAIL rst_href got=%b want=0", href_out); end
    n_cmp++; if (rgb_out !== 16'h0) begin n_fail++; $display("FAIL rst_rgb got=%h want=0000", rgb_out); end
    n_cmp++; if (overrun !== 1'b0 || short_line !== 1'b0 || vsync_out !== 1'b0) begin n_fail++; $display("FAIL rst_flags got=%b%b%b want=000", overrun, short_line, vsync_out); end
    repeat (SAFE_PERIOD) @(negedge pclk_in);
    clear_capture();
    fill_line(1'b0); expect_line(); send_line(IN_X, 15, SAFE_PERIOD);
    repeat (2 * SAFE_PERIOD) @(negedge pclk_in);
    n_cmp++; if (got_len.size() != 2) begin n_fail++; $display("FAIL rst_bursts got=%0d want=2", got_len.size()); end
    n_cmp++; if (got_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL rst_count got=%0d want=%0d", got_pix.size(), exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL rst_pix[%0d] got=%h want=%h", i, got_pix[i], exp_pix[i]); end
    end
  endtask

  initial begin
    low_nz = 0; prev_h = 0; run_len = 0; gap_len = 0; seen_fall = 0;
    @(negedge pclk_in);
    test_reset();
    test_single_line();
    test_random_frame();
    test_overrun();
    test_short_line();
    test_vsync_flush();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
